ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/ex_stage_if.sv | 37 +++
 rtl/ex_stage_alu.sv | 31 +++
 rtl/ex_stage.sv | 74 +++++++
 tb/tb_ex_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU operation select, writeback select,
// and the forwarding match helper.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    // A producer can only forward when it writes a non-x0 register that matches the source.
    function automatic logic fwd_hit(input logic wen, input logic [REG_AW-1:0] dst,
                                     input logic [REG_AW-1:0] src);
        return wen && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding path, pipeline control and EX/MEM outputs of the
// execute stage. The slave modport is the stage itself; master is the surrounding pipeline.
interface ex_stage_if;
    logic [31:0] pc_i, imm_i, data1_i, data2_i;
    logic [4:0]  RegDst_i, RegS1_i, RegS2_i;
    logic        ASel_i, BSel_i, MemR_i, MemW_i, RegWEn_i;
    logic [1:0]  WBSel_i;
    logic [3:0]  ALUSel_i;

    logic [4:0]  wb_RegDst_i;
    logic        wb_RegWEn_i;
    logic [31:0] wb_data_i;

    logic        stall_i, flush_i;

    logic [31:0] pc_o, alu_o, store_data_o;
    logic [4:0]  RegDst_o;
    logic        MemR_o, MemW_o, RegWEn_o;
    logic [1:0]  WBSel_o;
    logic        load_use_o;

    modport slave (
        input  pc_i, imm_i, data1_i, data2_i, RegDst_i, RegS1_i, RegS2_i,
               ASel_i, BSel_i, MemR_i, MemW_i, RegWEn_i, WBSel_i, ALUSel_i,
               wb_RegDst_i, wb_RegWEn_i, wb_data_i, stall_i, flush_i,
        output pc_o, alu_o, store_data_o, RegDst_o, MemR_o, MemW_o, RegWEn_o,
               WBSel_o, load_use_o
    );

    modport master (
        output pc_i, imm_i, data1_i, data2_i, RegDst_i, RegS1_i, RegS2_i,
               ASel_i, BSel_i, MemR_i, MemW_i, RegWEn_i, WBSel_i, ALUSel_i,
               wb_RegDst_i, wb_RegWEn_i, wb_data_i, stall_i, flush_i,
        input  pc_o, alu_o, store_data_o, RegDst_o, MemR_o, MemW_o, RegWEn_o,
               WBSel_o, load_use_o
    );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational integer ALU for the execute stage; unused select codes yield zero.
module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      sel,
    output logic [XLEN-1:0] y
);
    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (alu_op_e'(sel))
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt;
            ALU_SLT:   y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {31'd0, a < b};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Build with FWD_EN defined to enable forwarding and load-use detection.
module ex_stage
    import riscv_pkg::*;
(
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave ex
);
    logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, alu_y;

`ifdef FWD_EN
    logic exm_fwd_ok;

    // A load's EX/MEM alu_o is only an address, so it must never be forwarded.
    assign exm_fwd_ok = ex.RegWEn_o & ~ex.MemR_o;

    always_comb begin
        rs1_val = ex.data1_i;
        if (fwd_hit(ex.wb_RegWEn_i, ex.wb_RegDst_i, ex.RegS1_i)) rs1_val = ex.wb_data_i;
        if (fwd_hit(exm_fwd_ok, ex.RegDst_o, ex.RegS1_i))        rs1_val = ex.alu_o;
    end

    always_comb begin
        rs2_val = ex.data2_i;
        if (fwd_hit(ex.wb_RegWEn_i, ex.wb_RegDst_i, ex.RegS2_i)) rs2_val = ex.wb_data_i;
        if (fwd_hit(exm_fwd_ok, ex.RegDst_o, ex.RegS2_i))        rs2_val = ex.alu_o;
    end

    assign ex.load_use_o = ex.MemR_o && (ex.RegDst_o != '0) &&
                           ((ex.RegDst_o == ex.RegS1_i) || (ex.RegDst_o == ex.RegS2_i));
`else
    logic unused_fwd;

    assign unused_fwd    = ^{ex.wb_RegDst_i, ex.wb_RegWEn_i, ex.wb_data_i,
                             ex.RegS1_i, ex.RegS2_i};
    assign rs1_val       = ex.data1_i;
    assign rs2_val       = ex.data2_i;
    assign ex.load_use_o = 1'b0;
`endif

    assign op_a = ex.ASel_i ? ex.pc_i  : rs1_val;
    assign op_b = ex.BSel_i ? ex.imm_i : rs2_val;

    alu u_alu (
        .a   (op_a),
        .b   (op_b),
        .sel (ex.ALUSel_i),
        .y   (alu_y)
    );

    // Flush beats stall so a bubble can always be inserted behind a held instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || ex.flush_i) begin
            ex.pc_o         <= '0;
            ex.alu_o        <= '0;
            ex.store_data_o <= '0;
            ex.RegDst_o     <= '0;
            ex.MemR_o       <= 1'b0;
            ex.MemW_o       <= 1'b0;
            ex.RegWEn_o     <= 1'b0;
            ex.WBSel_o      <= '0;
        end else if (!ex.stall_i) begin
            ex.pc_o         <= ex.pc_i;
            ex.alu_o        <= alu_y;
            ex.store_data_o <= rs2_val;
            ex.RegDst_o     <= ex.RegDst_i;
            ex.MemR_o       <= ex.MemR_i;
            ex.MemW_o       <= ex.MemW_i;
            ex.RegWEn_o     <= ex.RegWEn_i;
            ex.WBSel_o      <= ex.WBSel_i;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors, a behavioural EX/MEM model
// compared every falling edge, and literal checks that pin the model.
module tb_ex_stage;
    logic clk, rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_alu, m_sd;
    logic [4:0]  m_rd;
    logic        m_memr, m_memw, m_wen;
    logic [1:0]  m_wbsel;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
        logic [4:0] sh;
        sh = b[4:0];
        case (s)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a << sh;
            4'd3:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd4:  return {31'd0, a < b};
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_src(input logic [4:0] idx, input logic [31:0] dat);
        if (idx == 5'd0) return dat;
`ifdef FWD_EN
        if (m_wen && !m_memr && m_rd == idx) return m_alu;
        if (bus.wb_RegWEn_i && bus.wb_RegDst_i == idx) return bus.wb_data_i;
`endif
        return dat;
    endfunction

    function automatic logic ref_load_use();
`ifdef FWD_EN
        return m_memr && m_rd != 5'd0 && (m_rd == bus.RegS1_i || m_rd == bus.RegS2_i);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || bus.flush_i) begin
            m_pc <= 0; m_alu <= 0; m_sd <= 0; m_rd <= 0;
            m_memr <= 0; m_memw <= 0; m_wen <= 0; m_wbsel <= 0;
        end else if (!bus.stall_i) begin
            m_pc    <= bus.pc_i;
            m_alu   <= ref_alu(bus.ASel_i ? bus.pc_i : ref_src(bus.RegS1_i, bus.data1_i),
                               bus.BSel_i ? bus.imm_i : ref_src(bus.RegS2_i, bus.data2_i),
                               bus.ALUSel_i);
            m_sd    <= ref_src(bus.RegS2_i, bus.data2_i);
            m_rd    <= bus.RegDst_i;
            m_memr  <= bus.MemR_i;
            m_memw  <= bus.MemW_i;
            m_wen   <= bus.RegWEn_i;
            m_wbsel <= bus.WBSel_i;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("pc_o", bus.pc_o, m_pc);
            chk("alu_o", bus.alu_o, m_alu);
            chk("store_data_o", bus.store_data_o, m_sd);
            chk("RegDst_o", {27'd0, bus.RegDst_o}, {27'd0, m_rd});
            chk("MemR_o", {31'd0, bus.MemR_o}, {31'd0, m_memr});
            chk("MemW_o", {31'd0, bus.MemW_o}, {31'd0, m_memw});
            chk("RegWEn_o", {31'd0, bus.RegWEn_o}, {31'd0, m_wen});
            chk("WBSel_o", {30'd0, bus.WBSel_o}, {30'd0, m_wbsel});
            chk("load_use_o", {31'd0, bus.load_use_o}, {31'd0, ref_load_use()});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic asel, input logic bsel, input logic memr,
                         input logic memw, input logic wen, input logic [1:0] wbsel,
                         input logic [3:0] sel);
        bus.pc_i = pc; bus.imm_i = imm; bus.data1_i = d1; bus.data2_i = d2;
        bus.RegDst_i = rd; bus.RegS1_i = rs1; bus.RegS2_i = rs2;
        bus.ASel_i = asel; bus.BSel_i = bsel; bus.MemR_i = memr; bus.MemW_i = memw;
        bus.RegWEn_i = wen; bus.WBSel_i = wbsel; bus.ALUSel_i = sel;
    endtask

    task automatic wb(input logic [4:0] rd, input logic wen, input logic [31:0] d);
        bus.wb_RegDst_i = rd; bus.wb_RegWEn_i = wen; bus.wb_data_i = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pc_o"}, bus.pc_o, 32'd0);
        chk({tag, ".alu_o"}, bus.alu_o, 32'd0);
        chk({tag, ".store_data_o"}, bus.store_data_o, 32'd0);
        chk({tag, ".RegDst_o"}, {27'd0, bus.RegDst_o}, 32'd0);
        chk({tag, ".RegWEn_o"}, {31'd0, bus.RegWEn_o}, 32'd0);
        chk({tag, ".MemR_o"}, {31'd0, bus.MemR_o}, 32'd0);
        chk({tag, ".MemW_o"}, {31'd0, bus.MemW_o}, 32'd0);
    endtask

    logic [31:0] pat_a [3];
    logic [31:0] pat_b [3];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pat_a[0] = 32'h8000_0010; pat_b[0] = 32'h0000_0023;
        pat_a[1] = 32'h0000_00FF; pat_b[1] = 32'hFFFF_FFF0;
        pat_a[2] = 32'h1234_5678; pat_b[2] = 32'h1234_5678;

        rst = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        #1 rst = 1'b1;
        #1 chk_all_zero("reset");

        // ADD, captured on the first edge after reset release
        @(negedge clk); #2;
        rst = 1'b0;
        drive(32'h100, 0, 5, 7, 5, 1, 2, 0, 0, 0, 0, 1, 0, 4'd0);
        step();
        chk("add.alu_o", bus.alu_o, 32'd12);
        chk("add.store_data_o", bus.store_data_o, 32'd7);
        chk("add.pc_o", bus.pc_o, 32'h100);

        drive(32'h104, 4, 32'h8000_0000, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 4'd7);
        step();
        chk("sra.alu_o", bus.alu_o, 32'hF800_0000);

        drive(32'h108, 0, 5, 7, 0, 8, 9, 0, 0, 0, 0, 0, 0, 4'd1);
        step();
        chk("sub.alu_o", bus.alu_o, 32'hFFFF_FFFE);
        drive(32'h10C, 0, 32'hFFFF_FFFF, 1, 0, 8, 9, 0, 0, 0, 0, 0, 0, 4'd3);
        step();
        chk("slt.alu_o", bus.alu_o, 32'd1);
        drive(32'h10C, 0, 32'hFFFF_FFFF, 1, 0, 8, 9, 0, 0, 0, 0, 0, 0, 4'd4);
        step();
        chk("sltu.alu_o", bus.alu_o, 32'd0);

        // EX/MEM forwarding beats a simultaneous writeback of the same register
        drive(32'h110, 0, 5, 7, 3, 1, 2, 0, 0, 0, 0, 1, 0, 4'd0);
        step();
        drive(32'h114, 1, 0, 0, 7, 3, 0, 0, 1, 0, 0, 1, 0, 4'd0);
        wb(3, 1, 99);
        step();
`ifdef FWD_EN
        chk("fwd_exmem.alu_o", bus.alu_o, 32'd13);
`else
        chk("fwd_exmem.alu_o", bus.alu_o, 32'd1);
`endif
        wb(0, 0, 0);

        // load into x4, then a dependent store that stalls one cycle
        drive(32'h118, 8, 100, 0, 4, 10, 11, 0, 1, 1, 0, 1, 1, 4'd0);
        step();
        chk("load.alu_o", bus.alu_o, 32'd108);
        drive(32'h11C, 0, 200, 0, 0, 0, 4, 0, 1, 0, 1, 0, 0, 4'd0);
        bus.stall_i = 1'b1;
        #1;
`ifdef FWD_EN
        chk("load_use.flag", {31'd0, bus.load_use_o}, 32'd1);
`else
        chk("load_use.flag", {31'd0, bus.load_use_o}, 32'd0);
`endif
        step();
        chk("stall.alu_o", bus.alu_o, 32'd108);
        chk("stall.pc_o", bus.pc_o, 32'h118);
        chk("stall.MemR_o", {31'd0, bus.MemR_o}, 32'd1);
        chk("stall.RegDst_o", {27'd0, bus.RegDst_o}, 32'd4);
        bus.stall_i = 1'b0;
        wb(4, 1, 42);
        step();
`ifdef FWD_EN
        chk("wb_fwd.store_data_o", bus.store_data_o, 32'd42);
`else
        chk("wb_fwd.store_data_o", bus.store_data_o, 32'd0);
`endif
        chk("wb_fwd.MemW_o", {31'd0, bus.MemW_o}, 32'd1);
        chk("wb_fwd.alu_o", bus.alu_o, 32'd200);
        wb(0, 0, 0);

        // x0 is never a forwarding source, from EX/MEM or writeback
        drive(32'h120, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 4'd10);
        step();
        chk("x0.alu_o", bus.alu_o, 32'd9);
        drive(32'h124, 5, 0, 0, 6, 0, 0, 0, 1, 0, 0, 1, 0, 4'd0);
        wb(0, 1, 77);
        step();
        chk("x0_fwd.alu_o", bus.alu_o, 32'd5);
        chk("x0_fwd.store_data_o", bus.store_data_o, 32'd0);
        wb(0, 0, 0);

        // flush wins over stall
        drive(32'h128, 3, 1, 2, 8, 12, 13, 0, 0, 1, 1, 1, 1, 4'd0);
        bus.flush_i = 1'b1; bus.stall_i = 1'b1;
        step();
        chk_all_zero("flush");
        bus.flush_i = 1'b0; bus.stall_i = 1'b0;

        // every select code over a few operand pairs, chaining through x14
        for (int s = 0; s < 16; s++) begin
            for (int p = 0; p < 3; p++) begin
                drive(32'h200 + 32'(s * 16 + p), 0, pat_a[p], pat_b[p], 14, 14, 2,
                      0, 0, 0, 0, 1, 0, 4'(s));
                step();
            end
        end

        // reset between edges while stalled drops the held instruction
        drive(32'h300, 0, 3, 4, 9, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
        step();
        chk("pre_rst.alu_o", bus.alu_o, 32'd7);
        bus.stall_i = 1'b1;
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        #1 rst = 1'b0;
        bus.stall_i = 1'b0;
        drive(32'h304, 0, 10, 6, 2, 0, 0, 0, 0, 0, 0, 1, 0, 4'd1);
        step();
        chk("post_rst.alu_o", bus.alu_o, 32'd4);
        chk("post_rst.RegDst_o", {27'd0, bus.RegDst_o}, 32'd2);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
